// File: rtl/decode_ctrl_pipe.sv
// RV32 Decode-stage control decoder with ID/EX control register, illegal-op counter
// and optional M-extension divide busy sequencer (enabled by defining RV_MEXT_EN).
module decode_ctrl_pipe #(
    parameter int unsigned IMMSRC_W    = 3,
    parameter int unsigned ILL_CNT_W   = 8,
    parameter int unsigned DIV_LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_d,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic                 stall_e,
    input  logic                 flush_e,
    output logic [IMMSRC_W-1:0]  ImmSrcD,
    output logic                 illegal_d,
    output logic                 RegWriteE,
    output logic                 MemWriteE,
    output logic                 ALUSrcE,
    output logic                 JumpE,
    output logic                 JalrE,
    output logic                 BranchE,
    output logic [1:0]           ResultSrcE,
    output logic [1:0]           ALUOpE,
    output logic                 MulDivE,
    output logic                 validE,
    output logic                 illegalE,
    output logic                 div_busy,
    output logic [ILL_CNT_W-1:0] ill_count
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpIAlu   = 7'b0010011;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpJal    = 7'b1101111;

    localparam logic [6:0] F7Base   = 7'b0000000;
    localparam logic [6:0] F7Alt    = 7'b0100000;
`ifdef RV_MEXT_EN
    localparam logic [6:0] F7MulDiv = 7'b0000001;
`endif

    if (DIV_LATENCY < 2) begin : gDivLatencyCheck
        $error("decode_ctrl_pipe: DIV_LATENCY must be at least 2");
    end

    logic                legalD;
    logic                regWriteD;
    logic                memWriteD;
    logic                aluSrcD;
    logic                jumpD;
    logic                jalrD;
    logic                branchD;
    logic [1:0]          resultSrcD;
    logic [1:0]          aluOpD;
    logic [IMMSRC_W-1:0] immSelD;
    logic                mulDivD;
    logic                loadStep;

    // Main decoder: unrecognised encodings fall through with every control at 0.
    always_comb begin
        legalD     = 1'b1;
        regWriteD  = 1'b0;
        memWriteD  = 1'b0;
        aluSrcD    = 1'b0;
        jumpD      = 1'b0;
        jalrD      = 1'b0;
        branchD    = 1'b0;
        resultSrcD = 2'b00;
        aluOpD     = 2'b00;
        immSelD    = '0;
        mulDivD    = 1'b0;
        case (op)
            OpLoad: begin
                regWriteD  = 1'b1;
                aluSrcD    = 1'b1;
                resultSrcD = 2'b01;
            end
            OpStore: begin
                immSelD   = IMMSRC_W'(3'b001);
                aluSrcD   = 1'b1;
                memWriteD = 1'b1;
            end
            OpRType: begin
                if (funct7 == F7Base || funct7 == F7Alt) begin
                    regWriteD = 1'b1;
                    aluOpD    = 2'b10;
                end
`ifdef RV_MEXT_EN
                else if (funct7 == F7MulDiv) begin
                    regWriteD = 1'b1;
                    aluOpD    = 2'b10;
                    mulDivD   = 1'b1;
                end
`endif
                else begin
                    legalD = 1'b0;
                end
            end
            OpBranch: begin
                immSelD = IMMSRC_W'(3'b010);
                aluOpD  = 2'b01;
                branchD = 1'b1;
            end
            OpIAlu: begin
                regWriteD = 1'b1;
                aluSrcD   = 1'b1;
                aluOpD    = 2'b10;
            end
            OpAuipc: begin
                regWriteD  = 1'b1;
                immSelD    = IMMSRC_W'(3'b100);
                resultSrcD = 2'b11;
            end
            OpLui: begin
                regWriteD  = 1'b1;
                immSelD    = IMMSRC_W'(3'b101);
                resultSrcD = 2'b11;
            end
            OpJalr: begin
                if (funct3 == 3'b000) begin
                    regWriteD  = 1'b1;
                    aluSrcD    = 1'b1;
                    resultSrcD = 2'b10;
                    jalrD      = 1'b1;
                end else begin
                    legalD = 1'b0;
                end
            end
            OpJal: begin
                regWriteD  = 1'b1;
                immSelD    = IMMSRC_W'(3'b011);
                resultSrcD = 2'b10;
                jumpD      = 1'b1;
            end
            default: legalD = 1'b0;
        endcase
    end

    assign ImmSrcD   = immSelD;
    assign illegal_d = valid_d & ~legalD;
    assign loadStep  = ~flush_e & ~stall_e;

    // ID/EX control register: flush beats stall; an invalid slot loads all-zero controls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWriteE  <= 1'b0;
            MemWriteE  <= 1'b0;
            ALUSrcE    <= 1'b0;
            JumpE      <= 1'b0;
            JalrE      <= 1'b0;
            BranchE    <= 1'b0;
            ResultSrcE <= 2'b00;
            ALUOpE     <= 2'b00;
            validE     <= 1'b0;
            illegalE   <= 1'b0;
        end else if (flush_e) begin
            RegWriteE  <= 1'b0;
            MemWriteE  <= 1'b0;
            ALUSrcE    <= 1'b0;
            JumpE      <= 1'b0;
            JalrE      <= 1'b0;
            BranchE    <= 1'b0;
            ResultSrcE <= 2'b00;
            ALUOpE     <= 2'b00;
            validE     <= 1'b0;
            illegalE   <= 1'b0;
        end else if (!stall_e) begin
            RegWriteE  <= valid_d & regWriteD;
            MemWriteE  <= valid_d & memWriteD;
            ALUSrcE    <= valid_d & aluSrcD;
            JumpE      <= valid_d & jumpD;
            JalrE      <= valid_d & jalrD;
            BranchE    <= valid_d & branchD;
            ResultSrcE <= resultSrcD & {2{valid_d}};
            ALUOpE     <= aluOpD & {2{valid_d}};
            validE     <= valid_d;
            illegalE   <= illegal_d;
        end
    end

    // Saturating count of illegal instructions entering Execute.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ill_count <= '0;
        end else if (loadStep && illegal_d && (ill_count != {ILL_CNT_W{1'b1}})) begin
            ill_count <= ill_count + ILL_CNT_W'(1);
        end
    end

`ifdef RV_MEXT_EN
    localparam int unsigned CntW = (DIV_LATENCY > 2) ? $clog2(DIV_LATENCY) : 1;

    typedef enum logic {
        DivIdle = 1'b0,
        DivBusy = 1'b1
    } divStateT;

    divStateT        divState;
    divStateT        divStateNext;
    logic [CntW-1:0] divCnt;
    logic [CntW-1:0] divCntNext;
    logic            divStart;

    assign divStart = loadStep & valid_d & mulDivD & funct3[2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            MulDivE <= 1'b0;
        end else if (flush_e) begin
            MulDivE <= 1'b0;
        end else if (!stall_e) begin
            MulDivE <= valid_d & mulDivD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divState <= DivIdle;
            divCnt   <= '0;
        end else begin
            divState <= divStateNext;
            divCnt   <= divCntNext;
        end
    end

    // A new divide capture restarts the count even on the edge that would end BUSY.
    always_comb begin
        divStateNext = divState;
        divCntNext   = divCnt;
        if (flush_e) begin
            divStateNext = DivIdle;
            divCntNext   = '0;
        end else if (divStart) begin
            divStateNext = DivBusy;
            divCntNext   = CntW'(DIV_LATENCY - 1);
        end else if (divState == DivBusy) begin
            if (divCnt == '0) begin
                divStateNext = DivIdle;
            end else begin
                divCntNext = divCnt - CntW'(1);
            end
        end
    end

    always_comb begin
        div_busy = 1'b0;
        if (divState == DivBusy && divCnt != '0) begin
            div_busy = 1'b1;
        end
    end
`else
    assign MulDivE  = 1'b0;
    assign div_busy = 1'b0;
`endif

endmodule

// File: doc/decode_ctrl_pipe.md
# decode_ctrl_pipe

Parametrised next-generation control decoder for the pipelined RV32 core. It decodes opcode/funct3/funct7 in the Decode stage, drives the Decode-stage immediate select combinationally, and registers the remaining control bundle into the ID/EX boundary with stall, flush and bubble handling. It also flags illegal encodings, keeps a saturating illegal-instruction count, and optionally decodes the M extension with a multi-cycle divide busy sequencer for the hazard unit.

## Interface
- IMMSRC_W, 3: immediate-select width.
- ILL_CNT_W, 8: illegal-instruction counter width.
- DIV_LATENCY, 4: total Execute cycles of a divide/remainder op; legal range is ≥2.

- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high.
- valid_d  in  1  Decode-stage instruction valid.
- op  in  7  instr[6:0].
- funct3  in  3  instr[14:12].
- funct7  in  7  instr[31:25].
- stall_e  in  1  hold the ID/EX control register.
- flush_e  in  1  load a bubble into ID/EX.
- ImmSrcD  out  IMMSRC_W  combinational immediate select.
- illegal_d  out  1  combinational: valid_d and the encoding is not decodable.
- RegWriteE, MemWriteE, ALUSrcE, JumpE, JalrE, BranchE  out  1 each  registered controls.
- ResultSrcE  out  2  result-mux select.
- ALUOpE  out  2  ALU decoder class.
- MulDivE  out  1  M-extension op in Execute.
- validE  out  1  Execute slot holds a real instruction.
- illegalE  out  1  Execute slot holds an illegal instruction.
- div_busy  out  1  divide still in progress; the hazard unit stalls Decode and Execute.
- ill_count  out  ILL_CNT_W  saturating count of illegal instructions that entered Execute.

## Operation
- Decode fields are listed as RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, ALUOp, Jump, Jalr, Branch. No field is ever X; unused fields drive 0.
  - lw (0000011): 1, 000, 1, 0, 01, 00, 0, 0, 0
  - sw (0100011): 0, 001, 1, 1, 00, 00, 0, 0, 0
  - R-type (0110011), funct7 0000000 or 0100000: 1, 000, 0, 0, 00, 10, 0, 0, 0
  - branch (1100011): 0, 010, 0, 0, 00, 01, 0, 0, 1
  - I-ALU (0010011): 1, 000, 1, 0, 00, 10, 0, 0, 0
  - auipc (0010111): 1, 100, 0, 0, 11, 00, 0, 0, 0
  - lui (0110111): 1, 101, 0, 0, 11, 00, 0, 0, 0
  - jalr (1100111), funct3 000: 1, 000, 1, 0, 10, 00, 0, 1, 0
  - jal (1101111): 1, 011, 0, 0, 10, 00, 1, 0, 0
- Any other encoding is illegal, including jalr with funct3 ≠ 000 and R-type with any other funct7. An illegal encoding drives all controls 0, sets ImmSrcD to 0, and asserts illegal_d when valid_d is high.
- ID/EX update on each rising edge, in priority order:
  1. flush_e: load a bubble. All E outputs go to 0.
  2. stall_e: hold all E outputs.
  3. Otherwise: load the decoded bundle, with validE = valid_d and illegalE = illegal_d. If valid_d = 0, all controls load as 0.
- ill_count increments by 1 on each load step in which illegal_d = 1. It holds at all-ones.
- Div sequencer states are IDLE and BUSY, with a down-counter cnt.
  - IDLE → BUSY: a load step captures MulDivE = 1 and funct3[2] = 1. cnt is set to DIV_LATENCY−1.
  - BUSY: cnt decrements every cycle regardless of stall_e. div_busy = (state == BUSY) and (cnt ≠ 0).
  - BUSY → IDLE: when cnt reaches 0, or when flush_e = 1 (abort).
  - A multiply (funct3[2] = 0) never enters BUSY.

## Timing
- ImmSrcD and illegal_d have zero latency (combinational).
- E outputs have 1-cycle latency from D inputs.
- div_busy is high for exactly DIV_LATENCY−1 cycles, starting the cycle after the divide is captured.
- Reset (asynchronous) clears all E outputs, ill_count and cnt, and sets state to IDLE. ImmSrcD and illegal_d follow their inputs.
- Reset asserted mid-divide drops div_busy immediately, without waiting for a clock edge.
- flush_e and stall_e asserted together: the flush wins.
- A divide captured in the same edge that the sequencer leaves BUSY restarts BUSY on that edge.

## Configuration
- RV_MEXT_EN defined: R-type with funct7 0000001 decodes as 1, 000, 0, 0, 00, 10, 0, 0, 0 with MulDiv = 1, and the div sequencer is present.
- RV_MEXT_EN undefined: funct7 0000001 is illegal, MulDivE and div_busy are tied 0, and no sequencer logic is built.

## Test plan
- Reset then lw (op 0000011, valid_d 1): ImmSrcD = 000 immediately; next edge gives RegWriteE 1, ALUSrcE 1, ResultSrcE 01, validE 1.
- jal loaded while stall_e = 1 for 2 cycles: E outputs keep the prior instruction; jal appears one edge after stall_e falls. With stall_e = 1 and flush_e = 1 together, all E outputs are 0.
- op 1111111 with valid_d 1, repeated 300 times with ILL_CNT_W = 8: illegalE = 1 and all controls 0 on each; ill_count stops at 255. With valid_d = 0, ill_count does not change.
- RV_MEXT_EN defined, DIV_LATENCY 4, div (funct7 0000001, funct3 100): div_busy high for 3 cycles then low. mul (funct3 000): div_busy stays 0.
- Divide in progress with flush_e pulsed on the 2nd busy cycle: div_busy is 0 on the next cycle. Reset pulsed mid-busy: div_busy drops asynchronously.
- RV_MEXT_EN undefined, same div encoding: illegal_d = 1, MulDivE = 0, div_busy = 0.
